// File: rtl/frame_stack.sv
// LIFO of call frames for the recursive Fibonacci datapath.
// Top of stack is combinational on dout so pop and register load share a cycle.
module frame_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             udf
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    top_idx;

  // Wraps to DEPTH-1 when sp == DEPTH, which is exactly the top slot when full.
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == CW'(DEPTH));
  assign count   = sp_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign dout    = empty ? '0 : mem_q[top_idx];

  always_comb begin
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    wr_en   = 1'b0;
    wr_addr = sp_q[AW-1:0];
    case ({push, pop})
      2'b10: begin
        if (full) ovf_d = 1'b1;
        else begin
          wr_en = 1'b1;
          sp_d  = sp_q + 1'b1;
        end
      end
      2'b01: begin
        if (empty) udf_d = 1'b1;
        else       sp_d  = sp_q - 1'b1;
      end
      2'b11: begin
        // Empty push+pop degrades to a plain push but still records the bad pop.
        wr_en = 1'b1;
        if (empty) begin
          wr_addr = '0;
          sp_d    = CW'(1);
          udf_d   = 1'b1;
        end else begin
          wr_addr = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Storage is not reset; dout masks it while empty.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_addr] <= din;
  end
endmodule

// File: tb/tb_frame_stack.sv
// Scoreboard bench for frame_stack: a queue model predicts the post-edge state.
module tb_frame_stack;
  logic       clk = 1'b0;
  logic       rst, push, pop;
  logic [7:0] din, dout;
  logic       empty, full, ovf, udf;
  logic [4:0] count;

  frame_stack #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .dout(dout),
    .empty(empty), .full(full), .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dout;
    int         cnt;
    bit         ovf;
    bit         udf;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mstk[$];
  bit         movf, mudf;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mtop();
    return (mstk.size() == 0) ? 8'h00 : mstk[mstk.size()-1];
  endfunction

  // Drive one operation, predict the result, then compare after the edge.
  task automatic do_op(input bit p, input bit q, input logic [7:0] d);
    exp_t e;
    push = p; pop = q; din = d;
    chk("pre_dout", dout, mtop());
    if (p && !q) begin
      if (mstk.size() == 16) movf = 1; else mstk.push_back(d);
    end else if (!p && q) begin
      if (mstk.size() == 0) mudf = 1; else void'(mstk.pop_back());
    end else if (p && q) begin
      if (mstk.size() == 0) begin mstk.push_back(d); mudf = 1; end
      else mstk[mstk.size()-1] = d;
    end
    e.dout = mtop(); e.cnt = mstk.size(); e.ovf = movf; e.udf = mudf;
    sb.push_back(e);
    @(posedge clk); #1;
    push = 0; pop = 0;
    e = sb.pop_front();
    chk("dout",  dout,  e.dout);
    chk("count", count, e.cnt);
    chk("ovf",   ovf,   e.ovf);
    chk("udf",   udf,   e.udf);
    chk("empty", empty, e.cnt == 0);
    chk("full",  full,  e.cnt == 16);
  endtask

  initial begin
    rst = 1; push = 0; pop = 0; din = 0; movf = 0; mudf = 0;
    #12;
    chk("rst_empty", empty, 1); chk("rst_dout", dout, 0); chk("rst_count", count, 0);
    chk("rst_full", full, 0); chk("rst_ovf", ovf, 0); chk("rst_udf", udf, 0);
    rst = 0;

    for (int i = 1; i <= 16; i++) do_op(1, 0, 8'(i));
    chk("fill_full", full, 1); chk("fill_count", count, 16);
    chk("fill_dout", dout, 8'h10); chk("fill_ovf", ovf, 0);

    do_op(1, 0, 8'hAA);
    chk("ovf_count", count, 16); chk("ovf_dout", dout, 8'h10); chk("ovf_set", ovf, 1);

    for (int i = 16; i >= 1; i--) begin
      chk("drain_dout", dout, 8'(i));
      do_op(0, 1, 8'h00);
    end
    chk("drain_empty", empty, 1); chk("drain_dout0", dout, 0);

    do_op(0, 1, 8'h00);
    chk("udf_set", udf, 1); chk("udf_count", count, 0);
    do_op(1, 1, 8'h55);
    chk("pp_empty_count", count, 1); chk("pp_empty_dout", dout, 8'h55);

    do_op(0, 1, 8'h00);
    do_op(1, 0, 8'h03);
    do_op(1, 0, 8'h07);
    do_op(1, 1, 8'h09);
    chk("repl_count", count, 2); chk("repl_dout", dout, 8'h09);
    do_op(0, 1, 8'h00);
    chk("repl_pop_dout", dout, 8'h03);

    for (int i = 0; i < 4; i++) do_op(1, 0, 8'h40 + 8'(i));
    chk("pre_rst_count", count, 5);

    // Reset lands mid-cycle while push is held, and stays across an edge.
    push = 1; din = 8'hEE;
    #2 rst = 1;
    #1;
    chk("arst_count", count, 0); chk("arst_empty", empty, 1); chk("arst_dout", dout, 0);
    chk("arst_ovf", ovf, 0); chk("arst_udf", udf, 0);
    @(posedge clk); #1;
    chk("arst_push_ignored", count, 0);
    push = 0; rst = 0;
    mstk.delete(); movf = 0; mudf = 0;
    do_op(1, 0, 8'h21);
    chk("post_rst_count", count, 1); chk("post_rst_dout", dout, 8'h21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
